crossbar_rr_scheduler: RTL

//  Front-end scheduler for the one-hot-command crossbar (NUM_INPUT_DATA x NUM_OUTPUT_DATA).

---
 rtl/crossbar_rr_scheduler_if.sv | 27 ++
 rtl/crossbar_rr_scheduler.sv | 125 ++++++++++++
 2 files changed

// File: rtl/crossbar_rr_scheduler_if.sv
// crossbar_rr_scheduler_if: request side and crossbar-command side bundle of crossbar_rr_scheduler
interface crossbar_rr_scheduler_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 8,
    parameter int NUM_OUTPUT_DATA = 8
);
    localparam int DST_W = $clog2(NUM_OUTPUT_DATA);
    logic                                  en;
    logic [NUM_INPUT_DATA-1:0]             req_valid;
    logic [NUM_INPUT_DATA*DST_W-1:0]       req_dst;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  req_data;
    logic [NUM_INPUT_DATA-1:0]             req_ready;
    logic                                  xbar_en;
    logic [NUM_INPUT_DATA-1:0]             xbar_valid;
    logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  xbar_data;
    logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] xbar_cmd;
    logic [NUM_OUTPUT_DATA-1:0]            expect_valid;
    logic [15:0]                           conflict_cnt;
    modport master (
        output en, req_valid, req_dst, req_data,
        input  req_ready, xbar_en, xbar_valid, xbar_data, xbar_cmd, expect_valid, conflict_cnt
    );
    modport slave (
        input  en, req_valid, req_dst, req_data,
        output req_ready, xbar_en, xbar_valid, xbar_data, xbar_cmd, expect_valid, conflict_cnt
    );
endinterface

// File: rtl/crossbar_rr_scheduler.sv
// crossbar_rr_scheduler: per-output round-robin front end for the one-hot-command crossbar.
// Optional conflict statistics counter enabled by defining XBAR_SCHED_STATS_EN.
module crossbar_rr_scheduler #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 8,
    parameter int NUM_OUTPUT_DATA = 8,
    parameter int XBAR_LATENCY    = 8
) (
    input logic clk,
    input logic rst,
    crossbar_rr_scheduler_if.slave bus
);
    localparam int NI    = NUM_INPUT_DATA;
    localparam int NO    = NUM_OUTPUT_DATA;
    localparam int DW    = DATA_WIDTH;
    localparam int DST_W = $clog2(NO);
    localparam int SRC_W = $clog2(NI);

    logic [DST_W-1:0] dst [NI];
    logic [SRC_W-1:0] ptr [NO];
    logic [SRC_W-1:0] win [NO];
    logic [NI-1:0]    cand [NO];
    logic [NO-1:0]    hit;
    logic [SRC_W-1:0] idx;
    logic [NI-1:0]    ready;
    logic             live;

    logic                xen_q;
    logic [NI-1:0]       valid_q;
    logic [NI*DW-1:0]    data_q;
    logic [NI*NO-1:0]    cmd_q;
    logic [NO-1:0]       col;
    logic [NO-1:0]       pipe [XBAR_LATENCY];

    assign live = bus.en & ~rst;

    // Scan offsets high to low so the candidate closest above ptr is written last.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NI; i++)
            dst[i] = bus.req_dst[i*DST_W +: DST_W];
        for (int j = 0; j < NO; j++) begin
            win[j] = '0;
            hit[j] = 1'b0;
            for (int i = 0; i < NI; i++)
                cand[j][i] = bus.req_valid[i] & (dst[i] == DST_W'(j));
            for (int o = NI - 1; o >= 0; o--) begin
                idx = ptr[j] + SRC_W'(o);
                if (cand[j][idx]) begin
                    win[j] = idx;
                    hit[j] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NI; i++)
            ready[i] = live & hit[dst[i]] & (win[dst[i]] == SRC_W'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xen_q   <= 1'b0;
            valid_q <= '0;
            data_q  <= '0;
            cmd_q   <= '0;
            for (int j = 0; j < NO; j++)
                ptr[j] <= '0;
        end else begin
            xen_q   <= bus.en;
            valid_q <= ready;
            for (int i = 0; i < NI; i++) begin
                data_q[i*DW +: DW] <= ready[i] ? bus.req_data[i*DW +: DW] : '0;
                cmd_q[i*NO +: NO]  <= ready[i] ? NO'(1) << dst[i] : '0;
            end
            for (int j = 0; j < NO; j++)
                if (bus.en & hit[j])
                    ptr[j] <= win[j] + SRC_W'(1);
        end
    end

    always_comb begin
        col = '0;
        for (int i = 0; i < NI; i++)
            col = col | (cmd_q[i*NO +: NO] & {NO{valid_q[i]}});
    end

    // Advances only while the crossbar itself is enabled, keeping expect_valid aligned with its o_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < XBAR_LATENCY; k++)
                pipe[k] <= '0;
        end else if (xen_q) begin
            pipe[0] <= col;
            for (int k = 1; k < XBAR_LATENCY; k++)
                pipe[k] <= pipe[k-1];
        end
    end

`ifdef XBAR_SCHED_STATS_EN
    logic [15:0]    cnt;
    logic [SRC_W:0] lost;
    logic [16:0]    sum;
    always_comb begin
        lost = '0;
        for (int i = 0; i < NI; i++)
            lost = lost + (SRC_W+1)'(bus.req_valid[i] & ~ready[i]);
    end
    assign sum = {1'b0, cnt} + 17'(lost);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (bus.en)
            cnt <= sum[16] ? 16'hFFFF : sum[15:0];
    end
    assign bus.conflict_cnt = cnt;
`else
    assign bus.conflict_cnt = 16'h0;
`endif

    assign bus.req_ready    = ready;
    assign bus.xbar_en      = xen_q;
    assign bus.xbar_valid   = valid_q;
    assign bus.xbar_data    = data_q;
    assign bus.xbar_cmd     = cmd_q;
    assign bus.expect_valid = pipe[XBAR_LATENCY-1];
endmodule
